cnt_cmd_seq: RTL

- Command sequencer that sits directly upstream of the up/down counter.
- Accepts counter commands (LOAD, COUNT UP n, COUNT DOWN n, HOLD n) over a valid/ready interface and buffers them in a small FIFO.
- Drives the counter's control inputs ld_cnt, updn_cnt, count_enb and data_in cycle by cycle.

---
 rtl/cnt_cmd_seq_if.sv | 12 +
 rtl/cnt_cmd_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cnt_cmd_seq_if.sv
// rtl/cnt_cmd_seq_if.sv - command push channel into the counter command sequencer
interface cnt_cmd_seq_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/cnt_cmd_seq.sv
// rtl/cnt_cmd_seq.sv - FIFO-buffered command sequencer driving up/down counter controls
// Optional abort input enabled by macro CNT_CMD_SEQ_ABORT_EN.
module cnt_cmd_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef CNT_CMD_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  cnt_cmd_seq_if.slave          cmd,
  output logic                  ld_cnt,
  output logic                  updn_cnt,
  output logic                  count_enb,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  cmd_done,
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]     PTR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;
  localparam logic [LEN_WIDTH-1:0] LEN_TWO = 2;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH+1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q, rd_ptr_q;
  logic [1:0]            op_q, op_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  ld_q, ld_d, updn_q, updn_d, enb_q, enb_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  abort_w, empty, full, push, pop, last;
  logic [1:0]            head_op;
  logic [DATA_WIDTH-1:0] head_arg;
  logic [LEN_WIDTH-1:0]  head_len;

`ifdef CNT_CMD_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign cmd.cmd_ready = !full && !abort_w;
  assign push  = cmd.cmd_valid && cmd.cmd_ready;

  // LOAD and length 0/1 commands finish in the cycle they are issued
  assign last  = (state_q == EXEC) && ((op_q == OP_LOAD) || (rem_q <= LEN_ONE));
  assign pop   = !empty && !abort_w && ((state_q == IDLE) || last);

  assign {head_op, head_arg} = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign head_len = head_arg[LEN_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= {cmd.cmd_op, cmd.cmd_arg};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (abort_w) begin
      rd_ptr_q <= wr_ptr_q;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      rem_q   <= '0;
      ld_q    <= 1'b1;
      updn_q  <= 1'b0;
      enb_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      ld_q    <= ld_d;
      updn_q  <= updn_d;
      enb_q   <= enb_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_w)   state_d = IDLE;
    else if (pop)  state_d = EXEC;
    else if (last) state_d = IDLE;
  end

  // Outputs are registered, so this computes what the next cycle will show
  always_comb begin
    op_d   = op_q;
    rem_d  = rem_q;
    ld_d   = ld_q;
    updn_d = updn_q;
    enb_d  = enb_q;
    data_d = data_q;
    done_d = 1'b0;
    if (abort_w || (last && !pop)) begin
      ld_d  = 1'b1;
      enb_d = 1'b0;
    end else if (pop) begin
      op_d   = head_op;
      rem_d  = head_len;
      done_d = (head_op == OP_LOAD) || (head_len <= LEN_ONE);
      if (head_op == OP_LOAD) begin
        ld_d   = 1'b0;
        enb_d  = 1'b0;
        data_d = head_arg;
      end else begin
        ld_d  = 1'b1;
        enb_d = 1'b0;
        if (head_len != '0) begin
          if (head_op == OP_UP) begin
            enb_d  = 1'b1;
            updn_d = 1'b1;
          end else if (head_op == OP_DOWN) begin
            enb_d  = 1'b1;
            updn_d = 1'b0;
          end
        end
      end
    end else if (state_q == EXEC) begin
      rem_d  = rem_q - LEN_ONE;
      done_d = (rem_q == LEN_TWO);
    end
  end

  assign ld_cnt    = ld_q;
  assign updn_cnt  = updn_q;
  assign count_enb = enb_q;
  assign data_in   = data_q;
  assign cmd_done  = done_q;
  assign busy      = (state_q == EXEC) || !empty;

endmodule
